// File: rtl/len5_config_pkg.sv
// rtl/len5_config_pkg.sv - shared core configuration: PC width and boot address
package len5_config_pkg;

  localparam int unsigned XLEN = 64;
  localparam logic [XLEN-1:0] BOOT_PC = '0;

endpackage

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - frontend fetch PC generator with one buffered redirect
// Optional PCGEN_BPU_EN: taken BPU predictions steer the sequential PC.
module pc_gen #(
  parameter int unsigned          XLEN    = len5_config_pkg::XLEN,
  parameter logic [XLEN-1:0]      BOOT_PC = len5_config_pkg::BOOT_PC
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            comm_except_raised_i,
  input  logic [XLEN-1:0] comm_except_pc_i,
  input  logic            bu_res_valid_i,
  output logic            bu_res_ready_o,
  input  logic [XLEN-1:0] bu_res_pc_i,
  input  logic            bpu_taken_i,
  input  logic [XLEN-1:0] bpu_target_i,
  output logic            pc_valid_o,
  input  logic            mem_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic            redirect_o
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    WAIT_FE
  } pcgen_state_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

  pcgen_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] seq_pc;
  logic            fire;

  assign pc_valid_o     = (state_q != BOOT);
  assign bu_res_ready_o = (state_q != WAIT_FE) && !comm_except_raised_i;
  assign fire           = pc_valid_o && mem_ready_i;
  assign pc_o           = pc_q;
  assign redirect_o     = redirect_q;

`ifdef PCGEN_BPU_EN
  assign seq_pc = bpu_taken_i ? word_align(bpu_target_i) : pc_q + XLEN'(4);
`else
  logic unused_bpu;
  assign unused_bpu = ^{bpu_taken_i, bpu_target_i};
  assign seq_pc     = pc_q + XLEN'(4);
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    redirect_d = 1'b0;

    if (comm_except_raised_i) begin
      // The exception is the only event allowed to move pc_o during a stall.
      pc_d       = word_align(comm_except_pc_i);
      pend_pc_d  = '0;
      state_d    = RUN;
      redirect_d = 1'b1;
    end else begin
      unique case (state_q)
        BOOT: begin
          state_d = RUN;
          if (bu_res_valid_i) begin
            pc_d       = word_align(bu_res_pc_i);
            redirect_d = 1'b1;
          end
        end
        RUN: begin
          if (bu_res_valid_i) begin
            if (fire) begin
              pc_d       = word_align(bu_res_pc_i);
              redirect_d = 1'b1;
            end else begin
              pend_pc_d = word_align(bu_res_pc_i);
              state_d   = WAIT_FE;
            end
          end else if (fire) begin
            pc_d = seq_pc;
          end
        end
        WAIT_FE: begin
          if (fire) begin
            pc_d       = pend_pc_q;
            state_d    = RUN;
            redirect_d = 1'b1;
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= BOOT;
      pc_q       <= BOOT_PC;
      pend_pc_q  <= '0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      redirect_q <= redirect_d;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - self-checking bench for pc_gen (honours PCGEN_BPU_EN)
module tb_pc_gen;

  localparam logic [63:0] BOOT = 64'h1000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        comm_except_raised_i = 1'b0;
  logic [63:0] comm_except_pc_i = '0;
  logic        bu_res_valid_i = 1'b0;
  logic        bu_res_ready_o;
  logic [63:0] bu_res_pc_i = '0;
  logic        bpu_taken_i = 1'b0;
  logic [63:0] bpu_target_i = '0;
  logic        pc_valid_o;
  logic        mem_ready_i = 1'b1;
  logic [63:0] pc_o;
  logic        redirect_o;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state, in terms of the behavioural rules
  logic [63:0] m_pc, m_pend;
  bit          m_started, m_pending, m_redir;

  pc_gen #(.XLEN(64), .BOOT_PC(BOOT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .comm_except_raised_i(comm_except_raised_i), .comm_except_pc_i(comm_except_pc_i),
    .bu_res_valid_i(bu_res_valid_i), .bu_res_ready_o(bu_res_ready_o), .bu_res_pc_i(bu_res_pc_i),
    .bpu_taken_i(bpu_taken_i), .bpu_target_i(bpu_target_i),
    .pc_valid_o(pc_valid_o), .mem_ready_i(mem_ready_i),
    .pc_o(pc_o), .redirect_o(redirect_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_reset();
    m_pc = BOOT; m_pend = '0; m_started = 0; m_pending = 0; m_redir = 0;
  endtask

  task automatic model_step();
    bit started_now;
    m_redir = 0;
    started_now = m_started;
    if (comm_except_raised_i) begin
      m_pc = comm_except_pc_i & ~64'h3;
      m_pending = 0; m_started = 1; m_redir = 1;
    end else if (!started_now) begin
      m_started = 1;
      if (bu_res_valid_i) begin m_pc = bu_res_pc_i & ~64'h3; m_redir = 1; end
    end else if (m_pending) begin
      if (mem_ready_i) begin m_pc = m_pend; m_pending = 0; m_redir = 1; end
    end else if (bu_res_valid_i) begin
      if (mem_ready_i) begin m_pc = bu_res_pc_i & ~64'h3; m_redir = 1; end
      else begin m_pend = bu_res_pc_i & ~64'h3; m_pending = 1; end
    end else if (mem_ready_i) begin
`ifdef PCGEN_BPU_EN
      m_pc = bpu_taken_i ? (bpu_target_i & ~64'h3) : m_pc + 64'd4;
`else
      m_pc = m_pc + 64'd4;
`endif
    end
  endtask

  task automatic drive(input bit exc, input logic [63:0] epc, input bit bv,
                       input logic [63:0] bpc, input bit tk, input logic [63:0] tg,
                       input bit mr);
    comm_except_raised_i = exc; comm_except_pc_i = epc;
    bu_res_valid_i = bv; bu_res_pc_i = bpc;
    bpu_taken_i = tk; bpu_target_i = tg; mem_ready_i = mr;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 1);
    rst_ni = 1'b0;
    model_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1);
    @(posedge clk_i); @(posedge clk_i); #1;
    n_tests++;
    if (pc_o !== BOOT || pc_valid_o !== 1'b0 || bu_res_ready_o !== 1'b1 || redirect_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: pc=%h valid=%b ready=%b redir=%b, want pc=%h 0 1 0",
               pc_o, pc_valid_o, bu_res_ready_o, redirect_o, BOOT);
    end
    rst_ni = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if (pc_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL boot_valid: got %b want 0", pc_valid_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (pc_valid_o !== 1'b1 || pc_o !== BOOT + 64'(4 * i)) begin
        n_fail++;
        $display("FAIL boot_seq[%0d]: pc=%h valid=%b want pc=%h valid=1", i, pc_o, pc_valid_o,
                 BOOT + 64'(4 * i));
      end
    end
  endtask

  task automatic test_bu_stall();
    drive(1, 64'h2000, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 1, 64'h3000, 0, 0, 0);
    #1;
    n_tests++;
    if (pc_o !== 64'h2000 || redirect_o !== 1'b1 || bu_res_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_setup: pc=%h redir=%b ready=%b want 2000 1 1", pc_o, redirect_o, bu_res_ready_o);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    n_tests++;
    if (bu_res_ready_o !== 1'b0 || pc_o !== 64'h2000 || redirect_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_pending: ready=%b pc=%h redir=%b want 0 2000 0", bu_res_ready_o, pc_o, redirect_o);
    end
    tick();
    n_tests++;
    if (pc_o !== 64'h2000) begin
      n_fail++; $display("FAIL stall_hold: pc=%h want 2000", pc_o);
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    n_tests++;
    if (pc_o !== 64'h3000 || redirect_o !== 1'b1) begin
      n_fail++; $display("FAIL stall_release: pc=%h redir=%b want 3000 1", pc_o, redirect_o);
    end
    tick();
    n_tests++;
    if (pc_o !== 64'h3004 || redirect_o !== 1'b0 || bu_res_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_after: pc=%h redir=%b ready=%b want 3004 0 1", pc_o, redirect_o, bu_res_ready_o);
    end
  endtask

  task automatic test_bu_over_bpu();
    drive(0, 0, 1, 64'h5000, 1, 64'h4000, 1);
    tick();
    n_tests++;
    if (pc_o !== 64'h5000 || redirect_o !== 1'b1) begin
      n_fail++; $display("FAIL bu_over_bpu: pc=%h redir=%b want 5000 1", pc_o, redirect_o);
    end
  endtask

  task automatic test_exc_in_wait();
    drive(1, 64'h2000, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 1, 64'h3000, 0, 0, 0);
    tick();
    drive(1, 64'h8000, 0, 0, 0, 0, 0);
    #1;
    n_tests++;
    if (bu_res_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL exc_ready_mask: ready=%b want 0", bu_res_ready_o);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    n_tests++;
    if (pc_o !== 64'h8000 || redirect_o !== 1'b1 || bu_res_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL exc_in_wait: pc=%h redir=%b ready=%b want 8000 1 1", pc_o, redirect_o, bu_res_ready_o);
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    n_tests++;
    if (pc_o !== 64'h8004) begin
      n_fail++; $display("FAIL exc_pending_dropped: pc=%h want 8004", pc_o);
    end
  endtask

  task automatic test_wrap();
    drive(1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 0);
    tick();
    n_tests++;
    if (pc_o !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      n_fail++; $display("FAIL exc_align: pc=%h want fffffffffffffffc", pc_o);
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    n_tests++;
    if (pc_o !== 64'h0) begin
      n_fail++; $display("FAIL pc_wrap: pc=%h want 0", pc_o);
    end
  endtask

  task automatic test_bpu();
    logic [63:0] want;
`ifdef PCGEN_BPU_EN
    want = 64'h4000;
`else
    want = 64'h1004;
`endif
    drive(1, 64'h1000, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 64'h4000, 1);
    tick();
    n_tests++;
    if (pc_o !== want || redirect_o !== 1'b0) begin
      n_fail++; $display("FAIL bpu_taken: pc=%h redir=%b want %h 0", pc_o, redirect_o, want);
    end
  endtask

  task automatic test_reset_in_wait();
    drive(1, 64'h2000, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 1, 64'h3000, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    rst_ni = 1'b0;
    #1;
    n_tests++;
    if (pc_o !== BOOT || pc_valid_o !== 1'b0 || bu_res_ready_o !== 1'b1 || redirect_o !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_wait: pc=%h valid=%b ready=%b redir=%b want %h 0 1 0",
               pc_o, pc_valid_o, bu_res_ready_o, redirect_o, BOOT);
    end
    do_reset();
  endtask

  task automatic test_random();
    logic [63:0] a, b, c;
    for (int i = 0; i < 500; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      c = {$urandom, $urandom};
      drive($urandom_range(0, 15) == 0, a, $urandom_range(0, 9) < 3, b,
            $urandom_range(0, 1) == 1, c, $urandom_range(0, 9) < 6);
      #1;
      n_tests++;
      if (pc_o !== m_pc || redirect_o !== m_redir || pc_valid_o !== m_started ||
          bu_res_ready_o !== (!m_pending && !comm_except_raised_i)) begin
        n_fail++;
        $display("FAIL random[%0d]: pc=%h redir=%b valid=%b ready=%b want pc=%h redir=%b valid=%b ready=%b",
                 i, pc_o, redirect_o, pc_valid_o, bu_res_ready_o, m_pc, m_redir, m_started,
                 !m_pending && !comm_except_raised_i);
      end
      tick();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_bu_stall();
    test_bu_over_bpu();
    test_exc_in_wait();
    test_wrap();
    test_bpu();
    test_reset_in_wait();
    test_random();
    do_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Frontend program counter generator. It holds the fetch PC and presents it to the instruction fetch unit with a valid/ready handshake. It selects the next PC from, in priority order: commit exception, branch-unit misprediction redirect, BPU taken prediction, sequential PC+4. It is the consumer of the branch control unit's PC-reload request (`fe_pcgen_valid`/`fe_pcgen_ready`), and it buffers one redirect while the fetch handshake is stalled.

## Interface
- `XLEN`, 64, PC width in bits.
- `BOOT_PC`, 64'h0, PC loaded on reset. Bits [1:0] are zero.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `comm_except_raised_i` in 1: commit raises an exception or trap redirect.
- `comm_except_pc_i` in XLEN: handler address.
- `bu_res_valid_i` in 1: branch unit requests a PC reload after a misprediction.
- `bu_res_ready_o` out 1: redirect accepted.
- `bu_res_pc_i` in XLEN: correct target.
- `bpu_taken_i` in 1: BPU predicts taken for `pc_o`.
- `bpu_target_i` in XLEN: predicted target.
- `pc_valid_o` out 1: `pc_o` is valid for fetch.
- `mem_ready_i` in 1: fetch accepts `pc_o`.
- `pc_o` out XLEN: current fetch PC, also fed to the BPU.
- `redirect_o` out 1: the PC presented this cycle is the first after a redirect.

## Operation
- States:
  - BOOT: one cycle after reset.
  - RUN
  - WAIT_FE: a redirect is pending.
- Fire means `pc_valid_o && mem_ready_i`.
- Stable rule: while `pc_valid_o && !mem_ready_i`, `pc_o` must not change. The only exception to this rule is a commit exception.
- BOOT:
  - `pc_valid_o`=0, `bu_res_ready_o`=1.
  - Next state is always RUN.
  - A BU redirect accepted here loads `pc_q` directly.
- RUN, `pc_valid_o`=1, `bu_res_ready_o`=1:
  - BU redirect with no fire and `pc_valid_o && !mem_ready_i`: capture the target into `pend_pc_q` and go to WAIT_FE. `pc_q` holds.
  - BU redirect otherwise (fire this cycle): `pc_q` <= `bu_res_pc_i` and `redirect_o` is set next cycle. The BU redirect overrides the BPU and PC+4.
  - Fire with no redirect: `pc_q` <= `bpu_taken_i` ? `bpu_target_i` : `pc_q`+4.
  - Otherwise `pc_q` holds.
- WAIT_FE, `pc_valid_o`=1, `bu_res_ready_o`=0:
  - On fire: `pc_q` <= `pend_pc_q`, state RUN, `redirect_o` set next cycle. The BPU prediction is ignored.
- Commit exception (any state): `pc_q` <= `comm_except_pc_i`, pending redirect discarded, state RUN, `redirect_o` set next cycle. `bu_res_ready_o` is forced to 0 in that cycle.
- Loaded targets (BU, exception, BPU) have bits [1:0] cleared.
- PC+4 wraps modulo 2^XLEN.

## Timing
- Reset values:
  - `pc_q`=`BOOT_PC`, state BOOT, `pend_pc_q`=0.
  - `pc_valid_o`=0, `bu_res_ready_o`=1, `redirect_o`=0, `pc_o`=`BOOT_PC`.
- `pc_o` and `redirect_o` are registered. `bu_res_ready_o` and `pc_valid_o` are decoded from state only, plus the exception mask on ready.
- Redirect latency: the new PC appears on `pc_o` 1 cycle after acceptance, or 1 cycle after the fire that releases WAIT_FE.
- `redirect_o` lasts exactly one cycle unless back-to-back redirects occur.
- Simultaneous exception and BU valid: the exception wins and the BU request stays pending upstream (not accepted). The branch CU is flushed by the same commit event.
- Reset asserted mid-WAIT_FE: everything returns to reset values asynchronously.

## Configuration
- `PCGEN_BPU_EN`
  - Defined: a taken BPU prediction redirects the sequential PC on fire.
  - Undefined: `bpu_taken_i`/`bpu_target_i` are ignored and the next PC is always PC+4. Redirect and exception behaviour is unchanged.

## Structure
- The `pcgen_state_t` enum (BOOT, RUN, WAIT_FE) is local to the module.
- `BOOT_PC` default and `XLEN` come from the shared `len5_config_pkg`.
- No sub-module: the single pending register and FSM are inline.

## Test plan
- Reset with `BOOT_PC`=0x1000, `mem_ready_i`=1: `pc_valid_o` rises after 1 cycle; `pc_o` sequence is 0x1000, 0x1004, 0x1008.
- `mem_ready_i`=0 at `pc_o`=0x2000, BU redirect to 0x3000: accepted (`bu_res_ready_o`=1 then 0); `pc_o` stays 0x2000 until ready; then `pc_o`=0x3000 with `redirect_o`=1 for one cycle.
- Fire with `bpu_taken_i`=1 and target 0x4000 while BU redirects to 0x5000: next `pc_o`=0x5000.
- WAIT_FE pending 0x3000 and exception to 0x8000 in the same cycle: `pc_o`=0x8000, pending dropped, `bu_res_ready_o`=0 that cycle.
- `pc_o`=0xFFFF_FFFF_FFFF_FFFC and fire: next `pc_o`=0x0.
- With `PCGEN_BPU_EN` undefined, `bpu_taken_i`=1 and target 0x4000 at `pc_o`=0x1000: next `pc_o`=0x1004.
